rr_arbiter4: RTL and testbench

//  4-requester round-robin arbiter with bounded grant hold, sitting directly upstream of the
//  2-to-4 enable decoder: w[1:0]/en drive the decoder's w/en, whose y0..y3 become the one-hot

---
 rtl/rr_arbiter4.sv | 94 +++++++++
 tb/tb_rr_arbiter4.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with registered grant (w/en) and bounded grant hold.
// The last grantee drops to lowest priority whenever its grant ends.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] req,
  output logic [1:0] w,
  output logic       en,
  output logic       timeout
);

  localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_GRANT   = 2'b01;
  localparam logic [1:0] S_RELEASE = 2'b10;

  logic [1:0]       state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       w_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic [2:0]       pick;

  // Returns {found, index} of the first set request scanning upward from p (mod 4).
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = p + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    w_nxt       = w;
    cnt_nxt     = cnt;
    timeout_nxt = 1'b0;
    pick        = rr_pick(req, ptr);
    case (state)
      S_GRANT: begin
        // A voluntary release wins over a coincident hold-limit expiry.
        if (!req[w]) begin
          state_nxt = S_RELEASE;
          ptr_nxt   = w + 2'd1;
        end else if ((MAX_HOLD != 0) && (cnt == CNT_LIM)) begin
          state_nxt   = S_RELEASE;
          ptr_nxt     = w + 2'd1;
          timeout_nxt = 1'b1;
        end else if (cnt != CNT_SAT) begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      S_IDLE, S_RELEASE: begin
        if (pick[2]) begin
          state_nxt = S_GRANT;
          w_nxt     = pick[1:0];
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= S_IDLE;
      ptr     <= 2'd0;
      cnt     <= '0;
      w       <= 2'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      w       <= w_nxt;
      timeout <= timeout_nxt;
    end
  end

  assign en = (state == S_GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: three instances (hold limits 4, 8, unlimited) share one
// request bus and are compared every cycle against a grant-level reference model.
module tb_rr_arbiter4;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] w_o  [N];
  logic       en_o [N];
  logic       to_o [N];

  int checks   = 0;
  int failures = 0;

  // Reference model: current grantee, how long it has held, who has priority next.
  bit         m_en   [N];
  logic [1:0] m_w    [N];
  bit         m_to   [N];
  int         m_ptr  [N];
  int         m_held [N];

  typedef logic [11:0] exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(4)) u_mh4 (
    .clk(clk), .nrst(nrst), .req(req), .w(w_o[0]), .en(en_o[0]), .timeout(to_o[0])
  );
  rr_arbiter4 #(.MAX_HOLD(8)) u_mh8 (
    .clk(clk), .nrst(nrst), .req(req), .w(w_o[1]), .en(en_o[1]), .timeout(to_o[1])
  );
  rr_arbiter4 #(.MAX_HOLD(0)) u_mh0 (
    .clk(clk), .nrst(nrst), .req(req), .w(w_o[2]), .en(en_o[2]), .timeout(to_o[2])
  );

  function automatic int lim_of(input int i);
    if (i == 0) return 4;
    if (i == 1) return 8;
    return 0;
  endfunction

  task automatic check(input string name, input int inst, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t actual=%0h expected=%0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_en[i]   = 1'b0;
      m_w[i]    = 2'd0;
      m_to[i]   = 1'b0;
      m_ptr[i]  = 0;
      m_held[i] = 0;
    end
  endtask

  // One clock edge of the arbiter's documented behaviour, given the request seen at that edge.
  task automatic model_step(input logic [3:0] r);
    for (int i = 0; i < N; i++) begin
      int lim;
      lim = lim_of(i);
      if (m_en[i]) begin
        if (!r[m_w[i]]) begin
          m_en[i]  = 1'b0;
          m_to[i]  = 1'b0;
          m_ptr[i] = (int'(m_w[i]) + 1) % 4;
        end else if (lim != 0 && m_held[i] == lim) begin
          m_en[i]  = 1'b0;
          m_to[i]  = 1'b1;
          m_ptr[i] = (int'(m_w[i]) + 1) % 4;
        end else begin
          m_held[i]++;
        end
      end else begin
        m_to[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!m_en[i] && r[(m_ptr[i] + k) % 4]) begin
            m_en[i]   = 1'b1;
            m_w[i]    = 2'((m_ptr[i] + k) % 4);
            m_held[i] = 1;
          end
        end
      end
    end
  endtask

  function automatic exp_t pack_exp();
    exp_t e;
    e = '0;
    for (int i = 0; i < N; i++) e[4*i +: 4] = {m_en[i], m_w[i], m_to[i]};
    return e;
  endfunction

  task automatic drive(input logic [3:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    sb_q.push_back(pack_exp());
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      check({tag, "_en"}, i, 4'(en_o[i]), 4'h0);
      check({tag, "_w"},  i, 4'(w_o[i]),  4'h0);
      check({tag, "_to"}, i, 4'(to_o[i]), 4'h0);
    end
  endtask

  // Asserts reset between edges and expects outputs to clear without a clock.
  task automatic async_reset_check();
    @(negedge clk);
    #1;
    check("pre_rst_en", 2, 4'(en_o[2]), 4'(m_en[2]));
    nrst = 1'b0;
    #1;
    check_all_zero("async_rst");
    req = 4'b0000;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("rst_held");
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (nrst && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        for (int i = 0; i < N; i++) begin
          check("en",      i, 4'(en_o[i]), 4'(e[4*i+3]));
          check("w",       i, 4'(w_o[i]),  4'(e[4*i+1 +: 2]));
          check("timeout", i, 4'(to_o[i]), 4'(e[4*i]));
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "simulation time limit reached");
  end

  initial begin : stimulus
    logic [3:0] rr;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (3) drive(4'b0000);

    repeat (3) drive(4'b1010);
    repeat (3) drive(4'b1000);
    repeat (3) drive(4'b0000);

    repeat (26) drive(4'b1111);
    repeat (3) drive(4'b0000);

    repeat (2) drive(4'b1000);
    repeat (2) drive(4'b0000);
    repeat (3) drive(4'b1001);
    repeat (3) drive(4'b0000);

    repeat (30) drive(4'b0100);
    repeat (3) drive(4'b0000);

    repeat (4) drive(4'b0001);
    repeat (3) drive(4'b0000);

    repeat (300) drive(4'b1111);
    async_reset_check();
    repeat (3) drive(4'b0000);

    rr = 4'b0000;
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
      end
      drive(rr);
    end
    repeat (3) drive(4'b0000);

    repeat (3) @(posedge clk);
    #3;
    check("sb_drained", 0, 4'(sb_q.size()), 4'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
